// File: rtl/pb_seq_ctrl.sv
// Pushbutton front end (sync, debounce, one-shot) feeding a Moore up/down count sequencer.
// Optional STEP auto-repeat is compiled in when AUTO_REPEAT_EN is defined.
module pb_seq_ctrl #(
  parameter int W          = 4,
  parameter int MAXV       = 2**W-1,
  parameter int DB_CNT     = 16,
  parameter int REPEAT_DLY = 64,
  parameter int REPEAT_PER = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [3:0]   PB,
  input  logic [W-1:0] LOAD_VAL,
  output logic [W-1:0] OUT,
  output logic [1:0]   Cout,
  output logic         STEP_OS,
  output logic         WRAP
);

  localparam int         CW      = $clog2(DB_CNT);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CNT - 1);
  localparam logic [W-1:0]  MAX_W   = W'(MAXV);

  if (MAXV < 1 || MAXV > 2**W-1 || DB_CNT < 2 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_cfg
    $error("pb_seq_ctrl: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_UP   = 2'b01,
    S_DOWN = 2'b10,
    S_HOLD = 2'b11
  } state_t;

  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    deb_q, deb_d, deb_d1_q;
  logic [CW-1:0] db_cnt_q [4];
  logic [CW-1:0] db_cnt_d [4];
  logic [3:0]    rise, pulse_d, pulse_q;
  logic          rep_fire;

  state_t        state_q, state_d;
  logic [W-1:0]  out_q, out_d;
  logic          saved_up_q, saved_up_d;
  logic          wrap_q, wrap_d;
  logic          step_acc;

  // A differing synced level must persist DB_CNT cycles before the debounced level follows.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) deb_d[i] = ~deb_q[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  assign rise = deb_q & ~deb_d1_q;

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RCW  = $clog2(RMAX + 1);
  localparam logic [RCW-1:0] REP_DLY_C = RCW'(REPEAT_DLY);
  localparam logic [RCW-1:0] REP_PER_C = RCW'(REPEAT_PER);

  logic [RCW-1:0] rep_cnt_q, rep_cnt_d;
  logic           rep_phase_q, rep_phase_d;

  // Phase 0 waits out the initial delay, phase 1 repeats at the shorter period.
  always_comb begin
    rep_fire    = 1'b0;
    rep_cnt_d   = rep_cnt_q;
    rep_phase_d = rep_phase_q;
    if (!deb_q[0]) begin
      rep_cnt_d   = '0;
      rep_phase_d = 1'b0;
    end else if (rise[0]) begin
      rep_cnt_d   = RCW'(1);
      rep_phase_d = 1'b0;
    end else if (rep_cnt_q == (rep_phase_q ? REP_PER_C : REP_DLY_C)) begin
      rep_fire    = 1'b1;
      rep_cnt_d   = RCW'(1);
      rep_phase_d = 1'b1;
    end else begin
      rep_cnt_d   = rep_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_phase_q <= rep_phase_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign pulse_d = {rise[3:1], rise[0] | rep_fire};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      deb_d1_q <= '0;
      pulse_q  <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q  <= PB;
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      deb_d1_q <= deb_q;
      pulse_q  <= pulse_d;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  // Only the highest-priority pulse (LOAD > HOLD > DIR > STEP) is acted on.
  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    saved_up_d = saved_up_q;
    wrap_d     = 1'b0;
    step_acc   = 1'b0;
    if (pulse_q[3]) begin
      out_d = (LOAD_VAL > MAX_W) ? MAX_W : LOAD_VAL;
    end else if (pulse_q[2]) begin
      case (state_q)
        S_UP:    begin state_d = S_HOLD; saved_up_d = 1'b1; end
        S_DOWN:  begin state_d = S_HOLD; saved_up_d = 1'b0; end
        S_HOLD:  state_d = saved_up_q ? S_UP : S_DOWN;
        default: state_d = state_q;
      endcase
    end else if (pulse_q[1]) begin
      case (state_q)
        S_IDLE, S_UP: state_d = S_DOWN;
        S_DOWN:       state_d = S_UP;
        default:      state_d = state_q;
      endcase
    end else if (pulse_q[0]) begin
      case (state_q)
        S_IDLE: begin
          step_acc = 1'b1;
          state_d  = S_UP;
        end
        S_UP: begin
          step_acc = 1'b1;
          if (out_q == MAX_W) begin out_d = '0; wrap_d = 1'b1; end
          else                      out_d = out_q + 1'b1;
        end
        S_DOWN: begin
          step_acc = 1'b1;
          if (out_q == '0) begin out_d = MAX_W; wrap_d = 1'b1; end
          else                   out_d = out_q - 1'b1;
        end
        default: step_acc = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      out_q      <= '0;
      saved_up_q <= 1'b1;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      saved_up_q <= saved_up_d;
      wrap_q     <= wrap_d;
    end
  end

  assign OUT     = out_q;
  assign Cout    = state_q;
  assign STEP_OS = step_acc;
  assign WRAP    = wrap_q;

endmodule

// File: doc/pb_seq_ctrl.md
Name: pb_seq_ctrl

Overview:
Parametrised pushbutton front end and Moore sequencer for board-level control of a W-bit up/down count.
- Four raw pushbuttons (STEP, DIR, HOLD, LOAD): each is synchronised, debounced and one-shot converted.
- The resulting pulses drive a 4-state Moore machine that steps, reverses, freezes or loads a registered count with wrap at a programmable maximum.
- Sits between board buttons and display/LED logic.

Parameters:
W, 4, width of count output OUT.
MAXV, 2**W-1, wrap limit of OUT; legal range 1..2**W-1.
DB_CNT, 16, consecutive stable synced cycles required to change a debounced level; minimum 2.
REPEAT_DLY, 64, cycles STEP must stay debounced-high before auto-repeat starts (AUTO_REPEAT_EN only).
REPEAT_PER, 16, cycles between auto-repeat pulses (AUTO_REPEAT_EN only).

Ports:
CLK  input  1  system clock, rising edge.
RST  input  1  asynchronous, active-high reset.
PB  input  4  raw buttons: [0]=STEP, [1]=DIR, [2]=HOLD, [3]=LOAD; asynchronous to CLK.
LOAD_VAL  input  W  value loaded on a LOAD pulse.
OUT  output  W  registered count.
Cout  output  2  registered state code: 00 IDLE, 01 UP, 10 DOWN, 11 HOLD.
STEP_OS  output  1  one-cycle pulse per accepted STEP event.
WRAP  output  1  one-cycle pulse when OUT wraps in either direction.

Behaviour:
- Reset (async assert, sync-released use): OUT=0, Cout=00, STEP_OS=0, WRAP=0; all sync flops, debounce counters, debounced levels, one-shot history and the saved direction cleared; saved direction = UP.
- Per button:
  - 2-flop synchroniser.
  - Debounce counter: resets to 0 whenever the synced value equals the debounced level, otherwise increments.
  - Reaching DB_CNT-1 while still differing flips the debounced level and clears the counter.
  - Glitches shorter than DB_CNT cycles produce no change.
- One-shot: pulse = debounced & ~debounced_d1. One cycle per rising debounced edge; falling edges produce nothing.
- Latency: raw edge stable from cycle 0 → synced at cycle 2 → debounced at 2+DB_CNT → pulse high at 3+DB_CNT → OUT/Cout updated at 4+DB_CNT.
- STEP_OS is the registered STEP pulse. It is high the same cycle the FSM consumes it; it only counts when the step is accepted (UP/DOWN/IDLE).
- FSM, state and OUT registered, Moore outputs:
  - IDLE: STEP → UP, OUT unchanged. DIR → DOWN. HOLD ignored.
  - UP: STEP → OUT+1; OUT==MAXV → OUT=0, WRAP=1. DIR → DOWN. HOLD → HOLD, saved dir=UP.
  - DOWN: STEP → OUT-1; OUT==0 → OUT=MAXV, WRAP=1. DIR → UP. HOLD → HOLD, saved dir=DOWN.
  - HOLD: STEP and DIR ignored, STEP_OS stays 0. HOLD → saved dir.
- LOAD in any state: OUT = min(LOAD_VAL, MAXV); state unchanged; WRAP=0.
- Simultaneous pulses in one cycle: priority LOAD > HOLD > DIR > STEP; only the highest acts, the rest are discarded.
- Arithmetic is modulo MAXV+1, never 2**W; OUT never exceeds MAXV.
- WRAP and STEP_OS are registered, one cycle wide, and never high for two consecutive cycles without two accepted steps.
- Reset mid-debounce or mid-repeat: everything clears; a button still held after reset must be re-debounced, and produces a pulse since the debounced level restarts at 0.

Optional Feature:
AUTO_REPEAT_EN:
- Defined: while the STEP debounced level stays high, a repeat counter starts at the one-shot.
  - After REPEAT_DLY cycles, one extra STEP pulse.
  - Then one every REPEAT_PER cycles until release.
  - Counter clears on release or reset.
  - Repeat pulses obey the same priority and HOLD rules as normal STEP pulses.
- Undefined: repeat logic absent; exactly one STEP pulse per press.

Test Plan:
1. W=4, MAXV=9, DB_CNT=4. Reset, then STEP held 10 cycles → STEP_OS high at cycle 7 after edge, Cout=01, OUT=0. Second press → OUT=1 at cycle 8.
2. From UP with OUT=9, STEP → OUT=0, WRAP=1 for one cycle. DIR press → Cout=10. STEP → OUT=9, WRAP=1.
3. STEP glitch of 3 cycles (DB_CNT=4) → no STEP_OS, OUT and Cout unchanged. Bounce train of 1-cycle toggles for 20 cycles, then stable high → exactly one pulse.
4. From DOWN, HOLD press → Cout=11; STEP presses ignored (OUT constant, STEP_OS=0); HOLD again → Cout=10.
5. LOAD_VAL=15 with MAXV=9 → OUT=9. LOAD and DIR pulses in the same cycle → OUT loaded, Cout unchanged. Assert RST mid-debounce → all outputs 0 immediately (async).
6. AUTO_REPEAT_EN, REPEAT_DLY=8, REPEAT_PER=4, STEP held 30 cycles after debounce → pulses at +0, +8, +12, +16, +20, +24, +28; none after release.
